// File: rtl/flag_branch_unit.sv
// rtl/flag_branch_unit.sv - EX/MEM pipeline register with NVZ flag commit and branch resolution
module flag_branch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic [3:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic [2:0]  alu_flags,
    input  logic        is_branch,
    input  logic [2:0]  cond,
    input  logic [15:0] branch_target,
    input  logic        reg_wr_en,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [3:0]  dst_reg,
    input  logic [15:0] store_data,
    output logic        mem_valid,
    output logic        mem_reg_wr_en,
    output logic        mem_rd_q,
    output logic        mem_wr_q,
    output logic [15:0] mem_alu_result,
    output logic [15:0] mem_store_data,
    output logic [3:0]  mem_dst_reg,
    output logic [2:0]  flags_q,
    output logic        branch_taken,
    output logic [15:0] branch_pc
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_SRA = 4'b0111;

    logic        r_mem_valid;
    logic        r_mem_reg_wr_en;
    logic        r_mem_rd_q;
    logic        r_mem_wr_q;
    logic [15:0] r_mem_alu_result;
    logic [15:0] r_mem_store_data;
    logic [3:0]  r_mem_dst_reg;
    logic [2:0]  r_flags;
    logic        r_branch_taken;
    logic [15:0] r_branch_pc;

    logic        w_n;
    logic        w_v;
    logic        w_z;
    logic        w_cond_true;
    logic        w_bubble;
    logic [2:0]  w_flags_next;

    assign w_n = r_flags[2];
    assign w_v = r_flags[1];
    assign w_z = r_flags[0];

    // Flush wins over stall, so a flushed stalled slot still becomes a bubble.
    assign w_bubble = flush | (~stall & ~ex_valid);

    always_comb begin
        w_cond_true = 1'b0;
        case (cond)
            3'b000:  w_cond_true = ~w_z;
            3'b001:  w_cond_true = w_z;
            3'b010:  w_cond_true = ~w_z & ~w_n;
            3'b011:  w_cond_true = w_n;
            3'b100:  w_cond_true = w_z | ~w_n;
            3'b101:  w_cond_true = w_n | w_z;
            3'b110:  w_cond_true = w_v;
            default: w_cond_true = 1'b1;
        endcase
    end

    always_comb begin
        w_flags_next = r_flags;
        if (!is_branch) begin
            if (alu_op == OP_ADD || alu_op == OP_SUB) begin
                w_flags_next = alu_flags;
            end else if (alu_op >= OP_AND && alu_op <= OP_SRA) begin
                w_flags_next[0] = alu_flags[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_valid      <= 1'b0;
            r_mem_reg_wr_en  <= 1'b0;
            r_mem_rd_q       <= 1'b0;
            r_mem_wr_q       <= 1'b0;
            r_mem_alu_result <= 16'h0000;
            r_mem_store_data <= 16'h0000;
            r_mem_dst_reg    <= 4'h0;
            r_flags          <= 3'b000;
            r_branch_taken   <= 1'b0;
            r_branch_pc      <= 16'h0000;
        end else if (w_bubble) begin
            r_mem_valid     <= 1'b0;
            r_mem_reg_wr_en <= 1'b0;
            r_mem_rd_q      <= 1'b0;
            r_mem_wr_q      <= 1'b0;
            r_branch_taken  <= 1'b0;
        end else if (stall) begin
            r_branch_taken <= 1'b0;
        end else begin
            r_mem_valid      <= 1'b1;
            r_mem_reg_wr_en  <= reg_wr_en;
            r_mem_rd_q       <= mem_rd;
            r_mem_wr_q       <= mem_wr;
            r_mem_alu_result <= alu_result;
            r_mem_store_data <= store_data;
            r_mem_dst_reg    <= dst_reg;
            r_flags          <= w_flags_next;
            r_branch_taken   <= is_branch & w_cond_true;
            if (is_branch && w_cond_true) begin
                r_branch_pc <= branch_target;
            end
        end
    end

    assign mem_valid      = r_mem_valid;
    assign mem_reg_wr_en  = r_mem_reg_wr_en;
    assign mem_rd_q       = r_mem_rd_q;
    assign mem_wr_q       = r_mem_wr_q;
    assign mem_alu_result = r_mem_alu_result;
    assign mem_store_data = r_mem_store_data;
    assign mem_dst_reg    = r_mem_dst_reg;
    assign flags_q        = r_flags;
    assign branch_taken   = r_branch_taken;
    assign branch_pc      = r_branch_pc;

endmodule

// File: tb/tb_flag_branch_unit.sv
// tb/tb_flag_branch_unit.sv - self-checking bench for flag_branch_unit
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, flush, ex_valid, is_branch;
    logic [3:0]  alu_op, dst_reg;
    logic [15:0] alu_result, branch_target, store_data;
    logic [2:0]  alu_flags, cond;
    logic        reg_wr_en, mem_rd, mem_wr;
    logic        mem_valid, mem_reg_wr_en, mem_rd_q, mem_wr_q, branch_taken;
    logic [15:0] mem_alu_result, mem_store_data, branch_pc;
    logic [3:0]  mem_dst_reg;
    logic [2:0]  flags_q;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    flag_branch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .alu_op(alu_op), .alu_result(alu_result), .alu_flags(alu_flags),
        .is_branch(is_branch), .cond(cond), .branch_target(branch_target),
        .reg_wr_en(reg_wr_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .dst_reg(dst_reg), .store_data(store_data),
        .mem_valid(mem_valid), .mem_reg_wr_en(mem_reg_wr_en), .mem_rd_q(mem_rd_q),
        .mem_wr_q(mem_wr_q), .mem_alu_result(mem_alu_result),
        .mem_store_data(mem_store_data), .mem_dst_reg(mem_dst_reg),
        .flags_q(flags_q), .branch_taken(branch_taken), .branch_pc(branch_pc)
    );

    typedef struct {
        logic        rst, stall, flush, ev, br;
        logic [3:0]  op;
        logic [2:0]  fl, cnd;
        logic [15:0] tgt;
        logic [2:0]  e_flags;
        logic        e_bt;
        logic [15:0] e_bpc;
        logic        e_mv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic s, logic f, logic ev, logic br,
                                logic [3:0] op, logic [2:0] fl, logic [2:0] cnd,
                                logic [15:0] tgt, logic [2:0] ef, logic ebt,
                                logic [15:0] ebpc, logic emv);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.ev = ev; v.br = br;
        v.op = op; v.fl = fl; v.cnd = cnd; v.tgt = tgt;
        v.e_flags = ef; v.e_bt = ebt; v.e_bpc = ebpc; v.e_mv = emv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; flush = 0; ex_valid = 0; is_branch = 0;
        alu_op = 4'h8; alu_result = 16'h0; alu_flags = 3'b000; cond = 3'b000;
        branch_target = 16'h0; reg_wr_en = 0; mem_rd = 0; mem_wr = 0;
        dst_reg = 4'h0; store_data = 16'h0;
    endtask

    // Reference model: which flag bits each opcode writes, and condition truth from NVZ.
    logic [2:0] wmask [16];

    function automatic logic cond_ok(input logic [2:0] c, input logic [2:0] f);
        logic n, v, z;
        n = f[2]; v = f[1]; z = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    logic        m_mv, m_rw, m_rd, m_wr, m_bt;
    logic [15:0] m_res, m_sd, m_bpc;
    logic [3:0]  m_dst;
    logic [2:0]  m_fl;

    task automatic model_next();
        if (rst) begin
            {m_mv, m_rw, m_rd, m_wr, m_bt} = '0;
            m_res = 0; m_sd = 0; m_bpc = 0; m_dst = 0; m_fl = 0;
        end else if (flush || (!stall && !ex_valid)) begin
            {m_mv, m_rw, m_rd, m_wr, m_bt} = '0;
        end else if (stall) begin
            m_bt = 0;
        end else begin
            m_mv = 1; m_rw = reg_wr_en; m_rd = mem_rd; m_wr = mem_wr;
            m_res = alu_result; m_sd = store_data; m_dst = dst_reg;
            m_bt = is_branch && cond_ok(cond, m_fl);
            if (m_bt) m_bpc = branch_target;
            if (!is_branch) m_fl = (m_fl & ~wmask[alu_op]) | (alu_flags & wmask[alu_op]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) wmask[i] = 3'b000;
        wmask[0] = 3'b111; wmask[2] = 3'b111;
        for (int i = 3; i <= 7; i++) wmask[i] = 3'b001;

        idle_inputs();
        rst = 1;

        //          rst s f ev br op    fl      cond    tgt       eflag  bt  bpc      mv
        vecs.push_back(mk(1,0,0,0,0, 4'h0, 3'b000, 3'd0, 16'h0000, 3'b000, 0, 16'h0000, 0));
        vecs.push_back(mk(0,0,0,1,0, 4'h0, 3'b110, 3'd0, 16'h0000, 3'b110, 0, 16'h0000, 1));
        vecs.push_back(mk(0,0,0,1,1, 4'h8, 3'b000, 3'd3, 16'h1234, 3'b110, 1, 16'h1234, 1));
        vecs.push_back(mk(0,0,0,0,0, 4'h8, 3'b000, 3'd0, 16'h0000, 3'b110, 0, 16'h1234, 0));
        vecs.push_back(mk(0,0,0,1,0, 4'h0, 3'b111, 3'd0, 16'h0000, 3'b111, 0, 16'h1234, 1));
        vecs.push_back(mk(0,0,0,1,0, 4'h3, 3'b000, 3'd0, 16'h0000, 3'b110, 0, 16'h1234, 1));
        vecs.push_back(mk(0,0,0,1,0, 4'h1, 3'b001, 3'd0, 16'h0000, 3'b110, 0, 16'h1234, 1));
        vecs.push_back(mk(0,0,0,1,0, 4'h8, 3'b001, 3'd0, 16'h0000, 3'b110, 0, 16'h1234, 1));
        vecs.push_back(mk(0,0,0,1,0, 4'h2, 3'b000, 3'd0, 16'h0000, 3'b000, 0, 16'h1234, 1));
        vecs.push_back(mk(0,0,0,1,1, 4'h8, 3'b000, 3'd7, 16'h0042, 3'b000, 1, 16'h0042, 1));
        vecs.push_back(mk(0,0,0,1,0, 4'h0, 3'b000, 3'd0, 16'h0000, 3'b000, 0, 16'h0042, 1));
        vecs.push_back(mk(0,0,0,1,1, 4'h8, 3'b000, 3'd6, 16'h5555, 3'b000, 0, 16'h0042, 1));
        vecs.push_back(mk(0,0,0,1,0, 4'h0, 3'b100, 3'd0, 16'h0000, 3'b100, 0, 16'h0042, 1));
        vecs.push_back(mk(0,0,0,1,1, 4'h8, 3'b000, 3'd4, 16'h6666, 3'b100, 0, 16'h0042, 1));
        vecs.push_back(mk(0,0,0,1,1, 4'h8, 3'b000, 3'd5, 16'h7777, 3'b100, 1, 16'h7777, 1));
        vecs.push_back(mk(0,0,0,1,1, 4'h0, 3'b111, 3'd0, 16'h1111, 3'b100, 1, 16'h1111, 1));
        vecs.push_back(mk(0,0,1,1,1, 4'h8, 3'b000, 3'd7, 16'h2222, 3'b100, 0, 16'h1111, 0));
        vecs.push_back(mk(0,1,1,1,1, 4'h8, 3'b000, 3'd7, 16'h3333, 3'b100, 0, 16'h1111, 0));
        vecs.push_back(mk(0,1,0,1,1, 4'h8, 3'b000, 3'd7, 16'h3333, 3'b100, 0, 16'h1111, 0));
        vecs.push_back(mk(0,0,0,1,1, 4'h8, 3'b000, 3'd7, 16'hABCD, 3'b100, 1, 16'hABCD, 1));
        vecs.push_back(mk(0,1,0,1,1, 4'h8, 3'b000, 3'd7, 16'hBBBB, 3'b100, 0, 16'hABCD, 1));
        vecs.push_back(mk(1,0,0,1,1, 4'h8, 3'b000, 3'd7, 16'hCCCC, 3'b000, 0, 16'h0000, 0));
        vecs.push_back(mk(0,0,0,1,0, 4'h0, 3'b111, 3'd0, 16'h0000, 3'b111, 0, 16'h0000, 1));
        vecs.push_back(mk(1,1,1,1,1, 4'h8, 3'b000, 3'd7, 16'hDDDD, 3'b000, 0, 16'h0000, 0));

        foreach (vecs[k]) begin
            rst = vecs[k].rst; stall = vecs[k].stall; flush = vecs[k].flush;
            ex_valid = vecs[k].ev; is_branch = vecs[k].br; alu_op = vecs[k].op;
            alu_flags = vecs[k].fl; cond = vecs[k].cnd; branch_target = vecs[k].tgt;
            alu_result = 16'h8000; reg_wr_en = vecs[k].ev & ~vecs[k].br;
            mem_rd = 0; mem_wr = 0; dst_reg = 4'h3; store_data = 16'h0F0F;
            step();
            chk($sformatf("vec%0d flags_q", k), 32'(flags_q), 32'(vecs[k].e_flags));
            chk($sformatf("vec%0d branch_taken", k), 32'(branch_taken), 32'(vecs[k].e_bt));
            chk($sformatf("vec%0d branch_pc", k), 32'(branch_pc), 32'(vecs[k].e_bpc));
            chk($sformatf("vec%0d mem_valid", k), 32'(mem_valid), 32'(vecs[k].e_mv));
            if (!vecs[k].e_mv)
                chk($sformatf("vec%0d bubble ctl", k),
                    32'({mem_reg_wr_en, mem_rd_q, mem_wr_q}), 32'd0);
        end

        // Load held across a three-cycle stall, then reset mid-stall.
        idle_inputs();
        ex_valid = 1; alu_op = 4'h0; alu_flags = 3'b101;
        step();
        chk("seed flags", 32'(flags_q), 32'(3'b101));
        alu_op = 4'h8; alu_flags = 3'b010; alu_result = 16'h00A0;
        reg_wr_en = 1; mem_rd = 1; dst_reg = 4'h5; store_data = 16'hBEEF;
        step();
        chk("lw ctl", 32'({mem_valid, mem_reg_wr_en, mem_rd_q, mem_wr_q}), 32'(4'b1110));
        chk("lw data", {mem_alu_result, mem_store_data}, 32'h00A0BEEF);
        chk("lw dst", 32'(mem_dst_reg), 32'd5);
        for (int c = 0; c < 3; c++) begin
            stall = 1; alu_op = 4'h0; alu_flags = 3'b010; alu_result = 16'h1111 * (c + 2);
            reg_wr_en = 0; mem_rd = 0; mem_wr = 1; dst_reg = 4'h9; store_data = 16'h5A5A;
            is_branch = 1; cond = 3'd7; branch_target = 16'h4444;
            step();
            chk($sformatf("stall%0d ctl", c),
                32'({mem_valid, mem_reg_wr_en, mem_rd_q, mem_wr_q}), 32'(4'b1110));
            chk($sformatf("stall%0d data", c), {mem_alu_result, mem_store_data}, 32'h00A0BEEF);
            chk($sformatf("stall%0d dst", c), 32'(mem_dst_reg), 32'd5);
            chk($sformatf("stall%0d flags", c), 32'(flags_q), 32'(3'b101));
            chk($sformatf("stall%0d bt", c), 32'(branch_taken), 32'd0);
        end
        rst = 1;
        step();
        chk("rst in stall ctl", 32'({mem_valid, mem_reg_wr_en, mem_rd_q, mem_wr_q, branch_taken}), 32'd0);
        chk("rst in stall data", {mem_alu_result, mem_store_data}, 32'd0);
        chk("rst in stall flags", 32'({flags_q, mem_dst_reg}), 32'd0);

        // Randomized run against the reference model.
        idle_inputs();
        rst = 1;
        model_next();
        step();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            ex_valid = ($urandom_range(0, 3) != 0);
            is_branch = ($urandom_range(0, 3) == 0);
            alu_op = 4'($urandom_range(0, 15));
            alu_flags = 3'($urandom);
            alu_result = 16'($urandom);
            cond = 3'($urandom);
            branch_target = 16'($urandom);
            reg_wr_en = 1'($urandom); mem_rd = 1'($urandom); mem_wr = 1'($urandom);
            dst_reg = 4'($urandom); store_data = 16'($urandom);
            model_next();
            step();
            chk("rnd ctl", 32'({mem_valid, mem_reg_wr_en, mem_rd_q, mem_wr_q}),
                32'({m_mv, m_rw, m_rd, m_wr}));
            chk("rnd data", {mem_alu_result, mem_store_data}, {m_res, m_sd});
            chk("rnd dst/flags", 32'({mem_dst_reg, flags_q}), 32'({m_dst, m_fl}));
            chk("rnd branch", 32'({branch_taken, branch_pc}), 32'({m_bt, m_bpc}));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
